// File: rtl/pcie_rc_scheduler_pkg.sv
// Shared constants and types for the host-to-FPGA DMA read scheduler.
// A block is 512 bytes: 64 qwords, addressed by host address bits [63:9].
// Each retired qword carries its end-of-block marker alongside the data.
package pcie_rc_scheduler_pkg;

  localparam int TAG_BITS_DEF = 5;
  localparam int QW_PER_TAG   = 64;
  localparam int QW_IDX_W     = 6;
  localparam int BLK_ADDR_W   = 55;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } qw_t;

endpackage

// File: rtl/pcie_rc_buffer.sv
// Purpose: simple dual-port qword store backing the per-tag reorder buffer.
// Latency: read data registered, valid the cycle after rd_en.
// Backpressure: none; writes always land, the caller paces reads.
module pcie_rc_buffer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Completion write port.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Synchronous retire read port.
  always_ff @(posedge clock) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/pcie_rc_scheduler.sv
// Purpose: DMA read scheduler; tags block reads, reorders completions per tag, retires blocks in issue order.
// Latency: request one cycle after accept; first retired qword three cycles after a block's final completion.
// Backpressure: rq held off while a request is pending or the pool is full; 2-entry output skid absorbs out_ready stalls.
module pcie_rc_scheduler
  import pcie_rc_scheduler_pkg::*;
#(
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rq_valid,
  output logic                  rq_ready,
  input  logic [BLK_ADDR_W-1:0] rq_addr,
  output logic                  tx_rd_valid,
  input  logic                  tx_rd_ready,
  output logic [BLK_ADDR_W-1:0] tx_rd_addr,
  output logic [7:0]            tx_rd_tag,
  input  logic                  completion_valid,
  input  logic [7:0]            completion_tag,
  input  logic [QW_IDX_W-1:0]   completion_index,
  input  logic [63:0]           completion_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_data,
  output logic                  out_last,
  output logic                  tag_error,
  output logic [TAG_BITS:0]     in_flight
);

  localparam int         NTAGS     = 2**TAG_BITS;
  localparam int         BUF_AW    = TAG_BITS + QW_IDX_W;
  localparam logic [6:0] QW_DONE   = 7'(QW_PER_TAG);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [TAG_BITS-1:0] wp, rp;
  logic [6:0]          qcount [NTAGS];
  logic [0:0]          state;
  logic [6:0]          rd_cnt;        // slots of block rp already read from the buffer
  logic                rd_pend, rd_pend_last;
  qw_t                 sk_mem [2];
  logic                sk_wp, sk_rp;
  logic [1:0]          sk_cnt;

  logic                rq_fire, tx_fire, cpl_ok, cpl_wr, pop, retire, rd_space, start, rd_en;
  logic [TAG_BITS-1:0] cpl_tag, cpl_ofs;
  logic [QW_IDX_W-1:0] rd_slot;
  logic [63:0]         buf_rd_dat;

  assign rq_ready  = !reset && !tx_rd_valid && !in_flight[TAG_BITS];
  assign rq_fire   = rq_valid && rq_ready;
  assign tx_fire   = tx_rd_valid && tx_rd_ready;
  assign tx_rd_tag = 8'(wp);

  // A tag is live when its distance past rp is inside the in-flight window.
  assign cpl_tag = completion_tag[TAG_BITS-1:0];
  assign cpl_ofs = cpl_tag - rp;
  assign cpl_ok  = ((completion_tag >> TAG_BITS) == 8'd0) && ({1'b0, cpl_ofs} < in_flight);
  assign cpl_wr  = completion_valid && cpl_ok;

  assign out_valid = (sk_cnt != 2'd0);
  assign out_data  = sk_mem[sk_rp].data;
  assign out_last  = sk_mem[sk_rp].last;
  assign pop       = out_valid && out_ready;
  assign retire    = pop && out_last;

  // Issue a read only if the skid still has room once the read already in the RAM lands.
  assign rd_space = (({1'b0, sk_cnt} + {2'b0, rd_pend}) - {2'b0, pop}) < 3'd2;
  assign start    = (state == ST_IDLE) && (in_flight != '0) && (qcount[rp] == QW_DONE) && rd_space;
  assign rd_en    = start || ((state == ST_STREAM) && !rd_cnt[6] && rd_space);
  assign rd_slot  = (state == ST_IDLE) ? '0 : rd_cnt[QW_IDX_W-1:0];

  pcie_rc_buffer #(.ADDR_W(BUF_AW), .DATA_W(64)) u_buffer (
    .clock   (clock),
    .wr_en   (cpl_wr),
    .wr_addr ({cpl_tag, completion_index}),
    .wr_dat  (completion_data),
    .rd_en   (rd_en),
    .rd_addr ({rp, rd_slot}),
    .rd_dat  (buf_rd_dat)
  );

  // Request register: hold one address until the TX arbiter takes it, then advance the issue pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_rd_valid <= 1'b0;
      tx_rd_addr  <= '0;
      wp          <= '0;
    end else if (rq_fire) begin
      tx_rd_valid <= 1'b1;
      tx_rd_addr  <= rq_addr;
    end else if (tx_fire) begin
      tx_rd_valid <= 1'b0;
      wp          <= wp + 1'b1;
    end
  end

  // Tags issued and not yet retired; issue and retire in one cycle cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight <= '0;
    end else begin
      case ({tx_fire, retire})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Per-tag completion counters; a fresh issue and a completion never touch the same tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NTAGS; i++) qcount[i] <= '0;
    end else begin
      if (rq_fire) qcount[wp] <= '0;
      if (cpl_wr)  qcount[cpl_tag] <= qcount[cpl_tag] + 1'b1;
    end
  end

  // Sticky flag for completions addressed to a tag outside the in-flight window.
  always_ff @(posedge clock) begin
    if (reset)                              tag_error <= 1'b0;
    else if (completion_valid && !cpl_ok)   tag_error <= 1'b1;
  end

  // Retire FSM: stream the oldest block's slots in order, advance rp when its last qword leaves.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      rd_cnt       <= '0;
      rp           <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_slot == 6'd63);
      if (start) begin
        state  <= ST_STREAM;
        rd_cnt <= 7'd1;
      end else if (state == ST_STREAM) begin
        if (rd_en) rd_cnt <= rd_cnt + 1'b1;
        if (retire) begin
          state <= ST_IDLE;
          rp    <= rp + 1'b1;
        end
      end
    end
  end

  // Two-entry output skid fed by the RAM read register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sk_mem[0] <= '0;
      sk_mem[1] <= '0;
      sk_wp     <= 1'b0;
      sk_rp     <= 1'b0;
      sk_cnt    <= '0;
    end else begin
      if (rd_pend) begin
        sk_mem[sk_wp] <= '{last: rd_pend_last, data: buf_rd_dat};
        sk_wp         <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      sk_cnt <= (sk_cnt + {1'b0, rd_pend}) - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pcie_rc_scheduler.sv
module tb_pcie_rc_scheduler;
  import pcie_rc_scheduler_pkg::*;

  localparam int NT = 32;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  rq_valid = 1'b0;
  logic                  rq_ready;
  logic [BLK_ADDR_W-1:0] rq_addr = '0;
  logic                  tx_rd_valid;
  logic                  tx_rd_ready = 1'b1;
  logic [BLK_ADDR_W-1:0] tx_rd_addr;
  logic [7:0]            tx_rd_tag;
  logic                  completion_valid = 1'b0;
  logic [7:0]            completion_tag = '0;
  logic [5:0]            completion_index = '0;
  logic [63:0]           completion_data = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [63:0]           out_data;
  logic                  out_last;
  logic                  tag_error;
  logic [5:0]            in_flight;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [64:0] got_q[$];          // {last, data} of every accepted output qword
  int          ref_blocks[$];     // tags issued and not yet checked, in issue order
  logic [63:0] ref_data [NT][64]; // qword values sent for each tag/slot
  int          model_wp = 0;

  always #5 clock = ~clock;

  pcie_rc_scheduler #(.TAG_BITS(5)) dut (
    .clock(clock), .reset(reset),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
    .tx_rd_valid(tx_rd_valid), .tx_rd_ready(tx_rd_ready), .tx_rd_addr(tx_rd_addr), .tx_rd_tag(tx_rd_tag),
    .completion_valid(completion_valid), .completion_tag(completion_tag),
    .completion_index(completion_index), .completion_data(completion_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .tag_error(tag_error), .in_flight(in_flight)
  );

  // Inputs only change just after a rising edge, so the falling edge shows what the next edge transfers.
  always @(negedge clock) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back({out_last, out_data});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rq_valid = 1'b0; completion_valid = 1'b0;
    tx_rd_ready = 1'b1; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    got_q.delete(); ref_blocks.delete(); model_wp = 0;
    tick();
  endtask

  task automatic issue_block(input logic [BLK_ADDR_W-1:0] addr, input int budget, output bit ok);
    bit seen;
    ok = 1'b0;
    rq_valid = 1'b1; rq_addr = addr;
    for (int n = 0; n < budget; n++) begin
      seen = rq_ready;
      tick();
      if (seen) begin ok = 1'b1; break; end
    end
    rq_valid = 1'b0;
    if (ok) begin
      n_checks++;
      if (tx_rd_valid !== 1'b1 || tx_rd_tag !== 8'(model_wp) || tx_rd_addr !== addr) begin
        n_fail++;
        $display("FAIL issue_req: got valid %b tag %0d addr %h, want 1 tag %0d addr %h",
                 tx_rd_valid, tx_rd_tag, tx_rd_addr, model_wp, addr);
      end
      seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
        seen = tx_rd_valid && tx_rd_ready;
        tick();
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL issue_tx_handshake: no handshake within %0d cycles", budget); end
      ref_blocks.push_back(model_wp);
      model_wp = (model_wp + 1) % NT;
    end
  endtask

  task automatic send_cpl(input logic [7:0] tag, input logic [5:0] idx, input logic [63:0] d);
    completion_valid = 1'b1; completion_tag = tag; completion_index = idx; completion_data = d;
    tick();
    completion_valid = 1'b0;
  endtask

  // Sends slots lo..hi of a tag, shuffled with random idle gaps when shuf is set.
  task automatic send_block(input int tag, input bit shuf, input int lo, input int hi);
    int ord[$];
    int j, t;
    logic [63:0] d;
    for (int i = lo; i <= hi; i++) ord.push_back(i);
    if (shuf) begin
      for (int i = ord.size() - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
    foreach (ord[k]) begin
      d = {$urandom, $urandom};
      ref_data[tag][ord[k]] = d;
      completion_valid = 1'b1; completion_tag = 8'(tag);
      completion_index = 6'(ord[k]); completion_data = d;
      tick();
      if (shuf && $urandom_range(3, 0) == 0) begin
        completion_valid = 1'b0;
        tick();
      end
    end
    completion_valid = 1'b0;
  endtask

  task automatic check_stream(input int nblocks, input string name);
    int need, n, tag;
    logic [64:0] act, exp_v;
    need = nblocks * 64;
    n = 0;
    while (got_q.size() < need && n < 20000) begin tick(); n++; end
    for (int b = 0; b < nblocks; b++) begin
      tag = ref_blocks.pop_front();
      for (int s = 0; s < 64; s++) begin
        exp_v = {s == 63, ref_data[tag][s]};
        n_checks++;
        if (got_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s missing: block %0d slot %0d got nothing, want %h", name, b, s, exp_v);
        end else begin
          act = got_q.pop_front();
          if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s data: block %0d slot %0d got %h want %h", name, b, s, act, exp_v);
          end
        end
      end
    end
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra: got %0d surplus qwords, want 0", name, got_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (rq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rq_ready: got %b want 0", rq_ready); end
    n_checks++;
    if ({tx_rd_valid, out_valid, out_last, tag_error} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {tx_rd_valid, out_valid, out_last, tag_error});
    end
    n_checks++;
    if (tx_rd_tag !== 8'd0 || tx_rd_addr !== '0) begin
      n_fail++; $display("FAIL reset_tx: got tag %h addr %h want 0 0", tx_rd_tag, tx_rd_addr);
    end
    n_checks++;
    if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_rq_ready: got %b want 1", rq_ready); end
    tick();
  endtask

  task automatic test_single_block();
    int run;
    tx_rd_ready = 1'b0;
    rq_valid = 1'b1; rq_addr = 55'h1;
    tick();
    rq_addr = 55'h2;
    tick(); tick();
    n_checks++;
    if (tx_rd_valid !== 1'b1 || tx_rd_tag !== 8'd0 || tx_rd_addr !== 55'h1 || rq_ready !== 1'b0 || in_flight !== 6'd0) begin
      n_fail++;
      $display("FAIL single_pending: got valid %b tag %0d addr %h rq_ready %b in_flight %0d, want 1 0 1 0 0",
               tx_rd_valid, tx_rd_tag, tx_rd_addr, rq_ready, in_flight);
    end
    rq_valid = 1'b0; tx_rd_ready = 1'b1;
    tick();
    ref_blocks.push_back(0); model_wp = 1;
    n_checks++;
    if (tx_rd_valid !== 1'b0 || in_flight !== 6'd1) begin
      n_fail++; $display("FAIL single_issued: got valid %b in_flight %0d, want 0 1", tx_rd_valid, in_flight);
    end
    send_block(0, 1'b0, 0, 63);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_n1: got out_valid %b want 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_n2: got out_valid %b want 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency_n3: got out_valid %b want 1", out_valid); end
    run = 0;
    for (int k = 0; k < 64; k++) begin
      if (out_valid !== 1'b1) break;
      run++;
      tick();
    end
    n_checks++;
    if (run != 64) begin n_fail++; $display("FAIL single_full_rate: got %0d consecutive valid cycles want 64", run); end
    check_stream(1, "single");
    tick();
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL single_in_flight_end: got %0d want 0", in_flight); end
  endtask

  task automatic test_reorder();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) issue_block(55'({$urandom, $urandom}), 10, ok);
    n_checks++;
    if (in_flight !== 6'd3) begin n_fail++; $display("FAIL reorder_in_flight: got %0d want 3", in_flight); end
    send_block(2, 1'b1, 0, 63);
    repeat (8) tick();
    n_checks++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reorder_early_out: got %0d qwords valid %b want 0 0", got_q.size(), out_valid);
    end
    send_block(0, 1'b1, 0, 63);
    send_block(1, 1'b1, 0, 63);
    check_stream(3, "reorder");
    tick();
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL reorder_in_flight_end: got %0d want 0", in_flight); end
  endtask

  task automatic test_bad_tag();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) issue_block(55'($urandom), 10, ok);
    n_checks++;
    if (tag_error !== 1'b0) begin n_fail++; $display("FAIL bad_tag_clear: got %b want 0", tag_error); end
    send_cpl(8'd5, 6'd3, 64'hdead_beef_0000_0005);
    n_checks++;
    if (tag_error !== 1'b1) begin n_fail++; $display("FAIL bad_tag_5: got %b want 1", tag_error); end
    do_reset();
    n_checks++;
    if (tag_error !== 1'b0) begin n_fail++; $display("FAIL bad_tag_reset: got %b want 0", tag_error); end
    for (int i = 0; i < 3; i++) issue_block(55'($urandom), 10, ok);
    send_block(0, 1'b0, 0, 31);
    send_cpl(8'h40, 6'd7, 64'hbad0_bad0_bad0_0040);
    n_checks++;
    if (tag_error !== 1'b1) begin n_fail++; $display("FAIL bad_tag_40: got %b want 1", tag_error); end
    send_block(0, 1'b1, 32, 63);
    send_block(1, 1'b1, 0, 63);
    send_block(2, 1'b1, 0, 63);
    check_stream(3, "bad_tag");
    repeat (10) tick();
    n_checks++;
    if (tag_error !== 1'b1) begin n_fail++; $display("FAIL bad_tag_sticky: got %b want 1", tag_error); end
  endtask

  task automatic test_full_pool();
    bit ok;
    int tags[$];
    int j, t;
    do_reset();
    for (int i = 0; i < NT; i++) begin
      issue_block(55'({$urandom, $urandom}), 10, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL pool_issue: request %0d got refused want accepted", i); end
    end
    n_checks++;
    if (in_flight !== 6'd32 || rq_ready !== 1'b0) begin
      n_fail++; $display("FAIL pool_full: got in_flight %0d rq_ready %b want 32 0", in_flight, rq_ready);
    end
    issue_block(55'h123, 6, ok);
    n_checks++;
    if (ok !== 1'b0) begin n_fail++; $display("FAIL pool_overflow: got accepted %b want 0", ok); end
    send_block(0, 1'b1, 0, 63);
    check_stream(1, "pool_tag0");
    tick();
    n_checks++;
    if (in_flight !== 6'd31 || rq_ready !== 1'b1) begin
      n_fail++; $display("FAIL pool_after_retire: got in_flight %0d rq_ready %b want 31 1", in_flight, rq_ready);
    end
    issue_block(55'h7_5555, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pool_reuse: got refused want accepted"); end
    for (int i = 1; i < NT; i++) tags.push_back(i);
    tags.push_back(0);
    for (int i = tags.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = tags[i]; tags[i] = tags[j]; tags[j] = t;
    end
    foreach (tags[k]) send_block(tags[k], 1'b0, 0, 63);
    check_stream(NT, "pool_rest");
    tick();
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL pool_in_flight_end: got %0d want 0", in_flight); end
  endtask

  task automatic test_backpressure();
    bit ok, held;
    logic [63:0] hdat;
    logic hlast;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) issue_block(55'($urandom), 10, ok);
    send_block(0, 1'b1, 0, 63);
    send_block(1, 1'b1, 0, 63);
    held = 1'b0; hdat = '0; hlast = 1'b0;
    for (int n = 0; n < 4000 && got_q.size() < 128; n++) begin
      out_ready = 1'($urandom_range(1, 0));
      if (held) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== hdat || out_last !== hlast) begin
          n_fail++;
          $display("FAIL bp_hold: got valid %b data %h last %b want 1 %h %b", out_valid, out_data, out_last, hdat, hlast);
        end
      end
      held = out_valid && !out_ready;
      hdat = out_data; hlast = out_last;
      tick();
    end
    out_ready = 1'b1;
    check_stream(2, "backpressure");
    tick();
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL bp_in_flight_end: got %0d want 0", in_flight); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int n;
    do_reset();
    issue_block(55'h1_2345_6789, 10, ok);
    send_cpl(8'h80, 6'd0, 64'h1);
    send_block(0, 1'b0, 0, 63);
    n = 0;
    while (got_q.size() < 20 && n < 500) begin tick(); n++; end
    n_checks++;
    if (got_q.size() < 20) begin n_fail++; $display("FAIL midreset_stream: got %0d qwords want 20", got_q.size()); end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({rq_ready, tx_rd_valid, out_valid, out_last, tag_error} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_flags: got %b want 00000", {rq_ready, tx_rd_valid, out_valid, out_last, tag_error});
    end
    n_checks++;
    if (tx_rd_tag !== 8'd0 || tx_rd_addr !== '0 || out_data !== 64'd0 || in_flight !== 6'd0) begin
      n_fail++;
      $display("FAIL midreset_values: got tag %h addr %h data %h in_flight %0d want all 0",
               tx_rd_tag, tx_rd_addr, out_data, in_flight);
    end
    reset = 1'b0;
    got_q.delete(); ref_blocks.delete(); model_wp = 0;
    tick();
    n_checks++;
    if (rq_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_rq_ready: got %b want 1", rq_ready); end
    issue_block(55'h1, 10, ok);
    send_block(0, 1'b0, 0, 63);
    check_stream(1, "midreset_fresh");
    tick();
    n_checks++;
    if (in_flight !== 6'd0) begin n_fail++; $display("FAIL midreset_in_flight_end: got %0d want 0", in_flight); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_reorder();
    test_bad_tag();
    test_full_pool();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
